// File: rtl/mem_access_pkg.sv
// mem_access_pkg: size encodings, FSM state type and byte-enable lookup shared by the memory access controller.
package mem_access_pkg;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [3:0] BE_BYTE    = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  function automatic logic [3:0] be_of(input logic [1:0] sz, input logic [1:0] lo);
    return sz == SZ_BYTE ? BE_BYTE << lo : sz == SZ_HALF ? (lo[1] ? BE_HALF_HI : BE_HALF_LO) : BE_WORD;
  endfunction
endpackage

// File: rtl/load_extract.sv
// load_extract: selects the addressed byte/half lane of a read word and sign- or zero-extends it.
module load_extract import mem_access_pkg::*; (
  input  logic [31:0] data,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  output logic [31:0] result
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = data[{addr_lo, 3'b000} +: 8];
    h = addr_lo[1] ? data[31:16] : data[15:0];
    result = size == SZ_BYTE ? {{24{~unsigned_ld & b[7]}}, b}
           : size == SZ_HALF ? {{16{~unsigned_ld & h[15]}}, h}
           : data;
  end
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding load/store sequencer with lane steering and ack timeout.
// Define MISALIGN_TRAP_EN to trap misaligned half/word ops instead of force-aligning them.
module mem_access_ctrl import mem_access_pkg::*; #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_store,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              err
);
  localparam logic [7:0] T_LAST = 8'(TIMEOUT - 1);
  state_t      state;
  logic [7:0]  cnt;
  logic        st_q, uns_q, mis;
  logic [1:0]  sz_q, lo_q, sz_n, lo_n;
  logic [31:0] wd_n, ext;
  always_comb begin
    sz_n = size == 2'd3 ? SZ_WORD : size;
    lo_n = sz_n == SZ_BYTE ? addr[1:0] : sz_n == SZ_HALF ? {addr[1], 1'b0} : 2'b00;
    wd_n = sz_n == SZ_BYTE ? {4{wdata[7:0]}} : sz_n == SZ_HALF ? {2{wdata[15:0]}} : wdata;
`ifdef MISALIGN_TRAP_EN
    mis = (sz_n == SZ_HALF && addr[0]) || (sz_n == SZ_WORD && addr[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
  end
  load_extract u_ext (
    .data(mem_rdata), .addr_lo(lo_q), .size(sz_q), .unsigned_ld(uns_q), .result(ext)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      {busy, mem_req, mem_we, done, err, st_q, uns_q} <= '0;
      {sz_q, lo_q} <= '0;
      mem_addr <= '0;
      mem_be <= '0;
      mem_wdata <= '0;
      rdata <= '0;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: if (start) begin
          st_q <= is_store;
          uns_q <= unsigned_ld;
          sz_q <= sz_n;
          lo_q <= lo_n;
          mem_addr <= {addr[ADDR_W-1:2], 2'b00};
          mem_be <= be_of(sz_n, lo_n);
          mem_wdata <= wd_n;
          cnt <= '0;
          busy <= 1'b1;
          state <= mis ? RESP : REQ;
          mem_req <= !mis;
          mem_we <= !mis && is_store;
          done <= mis;
          err <= mis;
        end
        REQ: if (mem_ack || cnt == T_LAST) begin
          // ack takes priority over a coincident timeout
          state <= RESP;
          mem_req <= 1'b0;
          mem_we <= 1'b0;
          done <= 1'b1;
          err <= !mem_ack;
          if (mem_ack && !st_q) rdata <= ext;
        end else cnt <= cnt + 8'd1;
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter ADDR_W, 32, byte-address width.
REQ-002 Parameter TIMEOUT, 15, max cycles in REQ waiting for mem_ack (1..255).
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  op request; sampled only in IDLE.
REQ-006 is_store  in  1  1 = store, 0 = load; sampled with start.
REQ-007 size  in  2  0 = byte, 1 = half, 2 = word, 3 = treated as word; sampled with start.
REQ-008 unsigned_ld  in  1  1 = zero-extend load, 0 = sign-extend; sampled with start.
REQ-009 addr  in  ADDR_W  byte address; sampled with start.
REQ-010 wdata  in  32  store data, right-justified; sampled with start.
REQ-011 busy  out  1  high in any state except IDLE.
REQ-012 mem_req  out  1  memory request, held until mem_ack or timeout.
REQ-013 mem_we  out  1  write strobe, valid while mem_req.
REQ-014 mem_addr  out  ADDR_W  word-aligned address (bits [1:0] = 0).
REQ-015 mem_be  out  4  byte-lane enables, little-endian.
REQ-016 mem_wdata  out  32  store data replicated into the addressed lanes.
REQ-017 mem_rdata  in  32  read data, valid in the mem_ack cycle.
REQ-018 mem_ack  in  1  memory completion, one cycle.
REQ-019 rdata  out  32  extended load result, held until the next done.
REQ-020 done  out  1  one-cycle completion pulse.
REQ-021 err  out  1  high only with done; misalignment or timeout.

Function
REQ-022 FSM states: IDLE, REQ, RESP. IDLE goes to REQ on start; REQ goes to RESP on mem_ack or timeout; RESP always returns to IDLE.
REQ-023 start in IDLE latches all request inputs, and mem_req rises the next cycle.
REQ-024 start while busy is ignored, with no queuing.
REQ-025 mem_ack is sampled only in REQ; in REQ, mem_rdata is captured, mem_req drops the next cycle, and done pulses in RESP.
REQ-026 Minimum latency is start edge to done = 2 cycles (mem_ack in the first REQ cycle).
REQ-027 Byte ops set mem_be = 1<<addr[1:0]; half ops set 4'b0011 or 4'b1100 by addr[1]; word ops set 4'b1111.
REQ-028 Stores replicate wdata: byte as {4{wdata[7:0]}}, half as {2{wdata[15:0]}}.
REQ-029 Loads select the lane by addr[1:0], then sign-extend or zero-extend per unsigned_ld; word loads pass through unchanged.
REQ-030 Stores leave rdata unchanged.
REQ-031 An 8-bit wait counter clears on REQ entry and increments each REQ cycle without mem_ack; when it reaches TIMEOUT, mem_req drops, the FSM goes to RESP, and err is set.
REQ-032 If mem_ack and the timeout occur in the same cycle, mem_ack wins (err = 0).
REQ-033 A mem_ack outside REQ is ignored.

Reset
REQ-034 Reset forces IDLE immediately with busy, mem_req, mem_we, done, err = 0, mem_be = 0, and mem_addr, mem_wdata, rdata = 0.
REQ-035 Reset mid-transaction abandons the transaction without producing done.

Configuration
REQ-036 Macro MISALIGN_TRAP_EN, when defined: a half op with addr[0] = 1, or a word op with addr[1:0] != 0, skips REQ, goes IDLE to RESP, never asserts mem_req, and pulses done with err = 1 and rdata unchanged.
REQ-037 When MISALIGN_TRAP_EN is undefined: the low address bits are forced aligned (half ignores addr[0], word ignores addr[1:0]), and misalignment never sets err.

Structure
REQ-038 Package mem_access_pkg holds the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state enum, and the mem_be lookup constants.
REQ-039 Sub-module load_extract is combinational: it takes rdata, addr[1:0], size, and unsigned_ld, and returns the 32-bit extended result. It is instantiated once.

Verification
REQ-040 LB with addr = 0x103, mem_rdata = 0x80FF_1234, ack in the first REQ cycle -> mem_be = 4'b1000, mem_addr = 0x100, rdata = 0xFFFF_FF80, done 2 cycles after start.
REQ-041 LHU with addr = 0x202, mem_rdata = 0x9ABC_0000 -> mem_be = 4'b1100, rdata = 0x0000_9ABC, err = 0.
REQ-042 SB with addr = 0x301, wdata = 0x0000_00A5 -> mem_we = 1, mem_be = 4'b0010, mem_wdata = 0xA5A5_A5A5, rdata unchanged.
REQ-043 LW with no ack, TIMEOUT = 15 -> mem_req high for 15 cycles, then done with err = 1; mem_ack and timeout in the same cycle -> err = 0.
REQ-044 LW with addr = 0x402: MISALIGN_TRAP_EN defined -> no mem_req, done with err = 1 one cycle after start; undefined -> mem_addr = 0x400, mem_be = 4'b1111, err = 0.
REQ-045 Reset asserted in REQ -> mem_req low immediately, no done; a start during busy -> ignored, with one transaction completed.
